control_sequencer: RTL

- Hardwired control unit that drives the DataPath control strobes through instruction fetch, decode and execute for a register-transfer instruction subset: ldi, addi, mfhi, mflo, mthi, mtlo, nop, halt.
- Replaces the hand-timed strobe sequences of the testbenches with a clocked Moore FSM.
- Sits beside DataPath and reads the opcode back from IR.

---
 rtl/cpu_ctrl_pkg.sv | 61 ++++++
 rtl/ctrl_strobe_decode.sv | 57 +++++
 rtl/control_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes, state
// encoding and the bit order of the strobe vector.
package cpu_ctrl_pkg;

   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ADDI = 5'b00010;
   localparam logic [4:0] OP_MTHI = 5'b10110;
   localparam logic [4:0] OP_MTLO = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [4:0] {
      ST_RST   = 5'd0,
      ST_F0    = 5'd1,
      ST_F1    = 5'd2,
      ST_F2    = 5'd3,
      ST_DEC   = 5'd4,
      ST_E3    = 5'd5,
      ST_E4    = 5'd6,
      ST_E5    = 5'd7,
      ST_DONE  = 5'd8,
      ST_PAUSE = 5'd9,
      ST_HALT  = 5'd10
   } state_t;

   localparam int NSTB = 24;
   localparam int SB_PCOUT    = 0;
   localparam int SB_PCIN     = 1;
   localparam int SB_INCPC    = 2;
   localparam int SB_MARIN    = 3;
   localparam int SB_MDRIN    = 4;
   localparam int SB_MDROUT   = 5;
   localparam int SB_MDREAD   = 6;
   localparam int SB_READ     = 7;
   localparam int SB_WRITE    = 8;
   localparam int SB_IRIN     = 9;
   localparam int SB_YIN      = 10;
   localparam int SB_ZLOWIN   = 11;
   localparam int SB_ZLOWOUT  = 12;
   localparam int SB_ADD      = 13;
   localparam int SB_CSIGNOUT = 14;
   localparam int SB_GRA      = 15;
   localparam int SB_GRB      = 16;
   localparam int SB_RIN      = 17;
   localparam int SB_ROUT     = 18;
   localparam int SB_BAOUT    = 19;
   localparam int SB_HIIN     = 20;
   localparam int SB_HIOUT    = 21;
   localparam int SB_LOIN     = 22;
   localparam int SB_LOOUT    = 23;

   typedef logic [NSTB-1:0] strobe_t;

   function automatic logic op_is_known(input logic [4:0] op);
      return op inside {OP_LDI, OP_ADDI, OP_MTHI, OP_MTLO,
                        OP_MFHI, OP_MFLO, OP_NOP, OP_HALT};
   endfunction

endpackage

// File: rtl/ctrl_strobe_decode.sv
// Combinational map from (state, latched opcode) to the DataPath strobe vector.
module ctrl_strobe_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int OPC_W = 5
) (
   input  state_t           state,
   input  logic [OPC_W-1:0] op,
   output strobe_t          stb
);

   always_comb begin
      stb = '0;
      case (state)
         ST_F0: begin
            stb[SB_PCOUT]  = 1'b1;
            stb[SB_MARIN]  = 1'b1;
            stb[SB_INCPC]  = 1'b1;
            stb[SB_ZLOWIN] = 1'b1;
         end
         ST_F1: begin
            stb[SB_ZLOWOUT] = 1'b1;
            stb[SB_PCIN]    = 1'b1;
            stb[SB_READ]    = 1'b1;
            stb[SB_MDREAD]  = 1'b1;
            stb[SB_MDRIN]   = 1'b1;
         end
         ST_F2: begin
            stb[SB_MDROUT] = 1'b1;
            stb[SB_IRIN]   = 1'b1;
         end
         ST_E3: begin
            case (op)
               OP_MFHI: begin stb[SB_HIOUT] = 1'b1; stb[SB_GRA] = 1'b1; stb[SB_RIN]  = 1'b1; end
               OP_MFLO: begin stb[SB_LOOUT] = 1'b1; stb[SB_GRA] = 1'b1; stb[SB_RIN]  = 1'b1; end
               OP_MTHI: begin stb[SB_GRA]   = 1'b1; stb[SB_ROUT] = 1'b1; stb[SB_HIIN] = 1'b1; end
               OP_MTLO: begin stb[SB_GRA]   = 1'b1; stb[SB_ROUT] = 1'b1; stb[SB_LOIN] = 1'b1; end
               OP_LDI:  begin stb[SB_GRB]   = 1'b1; stb[SB_BAOUT] = 1'b1; stb[SB_YIN] = 1'b1; end
               OP_ADDI: begin stb[SB_GRB]   = 1'b1; stb[SB_ROUT] = 1'b1; stb[SB_YIN]  = 1'b1; end
               default: ;
            endcase
         end
         ST_E4: begin
            stb[SB_CSIGNOUT] = 1'b1;
            stb[SB_ADD]      = 1'b1;
            stb[SB_ZLOWIN]   = 1'b1;
         end
         ST_E5: begin
            stb[SB_ZLOWOUT] = 1'b1;
            stb[SB_GRA]     = 1'b1;
            stb[SB_RIN]     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Moore control FSM for the fetch/decode/execute strobe sequences.
// Optional MEM_WAIT_EN adds mem_ready and stretches F1 until memory responds.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int OPC_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [OPC_W-1:0] ir_opcode,
   input  logic             stop,
`ifdef MEM_WAIT_EN
   input  logic             mem_ready,
`endif
   output logic             PCout,
   output logic             PCin,
   output logic             IncPC,
   output logic             MARin,
   output logic             MDRin,
   output logic             MDRout,
   output logic             MD_read,
   output logic             Read,
   output logic             Write,
   output logic             IRin,
   output logic             Yin,
   output logic             Zlowin,
   output logic             Zlowout,
   output logic             ADD,
   output logic             Csignout,
   output logic             Gra,
   output logic             Grb,
   output logic             Rin,
   output logic             Rout,
   output logic             BAout,
   output logic             HIin,
   output logic             HIout,
   output logic             LOin,
   output logic             LOout,
   output logic             run,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count,
   output logic [4:0]       present_state
);

   state_t           st, nxt;
   logic [OPC_W-1:0] op_q;
   logic             mem_ok;
   strobe_t          stb;

`ifdef MEM_WAIT_EN
   assign mem_ok = mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         st          <= ST_RST;
         op_q        <= '0;
         instr_count <= '0;
      end else begin
         st <= nxt;
         if (st == ST_DEC) op_q <= ir_opcode;
         if (st == ST_DONE) instr_count <= instr_count + CNT_W'(1);
      end
   end

   always_comb begin
      nxt = st;
      case (st)
         ST_RST: nxt = ST_F0;
         ST_F0:  nxt = ST_F1;
         ST_F1:  nxt = mem_ok ? ST_F2 : ST_F1;
         ST_F2:  nxt = ST_DEC;
         ST_DEC: begin
            case (ir_opcode)
               OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_LDI, OP_ADDI: nxt = ST_E3;
               OP_HALT: nxt = ST_HALT;
               default: nxt = ST_DONE;
            endcase
         end
         // Only the ALU-path instructions continue past E3.
         ST_E3:    nxt = (op_q == OP_LDI || op_q == OP_ADDI) ? ST_E4 : ST_DONE;
         ST_E4:    nxt = ST_E5;
         ST_E5:    nxt = ST_DONE;
         ST_DONE:  nxt = stop ? ST_PAUSE : ST_F0;
         ST_PAUSE: nxt = stop ? ST_PAUSE : ST_F0;
         ST_HALT:  nxt = ST_HALT;
         default:  nxt = ST_RST;
      endcase
   end

   ctrl_strobe_decode #(.OPC_W(OPC_W)) u_dec (
      .state (st),
      .op    (op_q),
      .stb   (stb)
   );

   assign run           = (st != ST_RST) && (st != ST_PAUSE) && (st != ST_HALT);
   assign illegal_op    = (st == ST_DEC) && !op_is_known(ir_opcode);
   assign present_state = st;

   assign PCout    = stb[SB_PCOUT];
   assign PCin     = stb[SB_PCIN];
   assign IncPC    = stb[SB_INCPC];
   assign MARin    = stb[SB_MARIN];
   assign MDRin    = stb[SB_MDRIN];
   assign MDRout   = stb[SB_MDROUT];
   assign MD_read  = stb[SB_MDREAD];
   assign Read     = stb[SB_READ];
   assign Write    = stb[SB_WRITE];
   assign IRin     = stb[SB_IRIN];
   assign Yin      = stb[SB_YIN];
   assign Zlowin   = stb[SB_ZLOWIN];
   assign Zlowout  = stb[SB_ZLOWOUT];
   assign ADD      = stb[SB_ADD];
   assign Csignout = stb[SB_CSIGNOUT];
   assign Gra      = stb[SB_GRA];
   assign Grb      = stb[SB_GRB];
   assign Rin      = stb[SB_RIN];
   assign Rout     = stb[SB_ROUT];
   assign BAout    = stb[SB_BAOUT];
   assign HIin     = stb[SB_HIIN];
   assign HIout    = stb[SB_HIOUT];
   assign LOin     = stb[SB_LOIN];
   assign LOout    = stb[SB_LOOUT];

endmodule
